// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op encodings, opcode/funct
// constants and the EX-stage control bundle.
package mips_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_NOP = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic       ALUsrc;
    logic [2:0] ALUop;
  } ctrl_t;

  // A bubble and the reset value are the same: no side effects, NOP ALU.
  localparam ctrl_t CTRL_BUBBLE = '{
    regWrite: 1'b0,
    memToReg: 1'b0,
    memRead:  1'b0,
    memWrite: 1'b0,
    ALUsrc:   1'b0,
    ALUop:    ALU_NOP
  };

endpackage

// File: rtl/hazard_detect.sv
// Load-use and branch-operand hazard detection for the ID stage.
// Purely combinational; branches resolve in ID so they need operands early.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             rtype_i,
  input  logic             sw_i,
  input  logic             beq_i,
  input  logic             bne_i,
  input  logic             j_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             ex_memRead_i,
  input  logic             ex_regWrite_i,
  input  logic [REG_W-1:0] ex_dest_i,
  input  logic             exmem_memRead_i,
  input  logic [REG_W-1:0] exmem_rd_i,
  output logic             stall_o
);

  logic uses_rt;
  logic is_br;
  logic m_ex;
  logic m_mem;
  logic load_use;
  logic br_ex;
  logic br_mem;

  assign uses_rt = rtype_i | sw_i | beq_i | bne_i;
  assign is_br   = beq_i | bne_i;

  assign m_ex = (ex_dest_i != '0) &&
                ((ex_dest_i == rs_i) ||
                 (uses_rt && (ex_dest_i == rt_i)));

  assign m_mem = (exmem_rd_i != '0) &&
                 ((exmem_rd_i == rs_i) ||
                  (uses_rt && (exmem_rd_i == rt_i)));

  assign load_use = ex_memRead_i & m_ex;
  assign br_ex    = is_br & ex_regWrite_i & m_ex;
  assign br_mem   = is_br & exmem_memRead_i & m_mem;

  // Jumps carry no register operands; the rs field is garbage for them.
  assign stall_o = ~j_i & (load_use | br_ex | br_mem);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion driven by hazard_detect.
// Also owns the upstream PC / IF-ID hold and a saturating bubble counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rtype,
  input  logic              lw,
  input  logic              sw,
  input  logic              beq,
  input  logic              bne,
  input  logic              j,
  input  logic              regWrite,
  input  logic              memToReg,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              ALUsrc,
  input  logic              regDest,
  input  logic [2:0]        ALUop,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] signExtImm,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic              exmem_memRead,
  input  logic [REG_W-1:0]  exmem_rd,
  output logic              ex_regWrite,
  output logic              ex_memToReg,
  output logic              ex_memRead,
  output logic              ex_memWrite,
  output logic              ex_ALUsrc,
  output logic [2:0]        ex_ALUop,
  output logic [DATA_W-1:0] ex_readData1,
  output logic [DATA_W-1:0] ex_readData2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_dest,
  output logic              pcWrite,
  output logic              ifidWrite,
  output logic              stall,
  output logic [CNT_W-1:0]  stallCount
);

  ctrl_t             ctrl_in;
  ctrl_t             ctrl_d, ctrl_q;
  logic [REG_W-1:0]  dest_d, dest_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
  logic [REG_W-1:0]  rs_q, rt_q;
  logic              hz;
  logic              unused_lw;

  assign unused_lw = lw;

  assign ctrl_in = '{
    regWrite: regWrite,
    memToReg: memToReg,
    memRead:  memRead,
    memWrite: memWrite,
    ALUsrc:   ALUsrc,
    ALUop:    ALUop
  };

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard (
    .rtype_i         (rtype),
    .sw_i            (sw),
    .beq_i           (beq),
    .bne_i           (bne),
    .j_i             (j),
    .rs_i            (rs),
    .rt_i            (rt),
    .ex_memRead_i    (ctrl_q.memRead),
    .ex_regWrite_i   (ctrl_q.regWrite),
    .ex_dest_i       (dest_q),
    .exmem_memRead_i (exmem_memRead),
    .exmem_rd_i      (exmem_rd),
    .stall_o         (hz)
  );

  always_comb begin
    ctrl_d = ctrl_in;
    dest_d = regDest ? rd : rt;
    cnt_d  = cnt_q;
    if (hz) begin
      ctrl_d = CTRL_BUBBLE;
      dest_d = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Data fields load even on a bubble: harmless, and keeps them defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= CTRL_BUBBLE;
      dest_q <= '0;
      cnt_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      dest_q <= dest_d;
      cnt_q  <= cnt_d;
      rd1_q  <= readData1;
      rd2_q  <= readData2;
      imm_q  <= signExtImm;
      rs_q   <= rs;
      rt_q   <= rt;
    end
  end

  assign ex_regWrite  = ctrl_q.regWrite;
  assign ex_memToReg  = ctrl_q.memToReg;
  assign ex_memRead   = ctrl_q.memRead;
  assign ex_memWrite  = ctrl_q.memWrite;
  assign ex_ALUsrc    = ctrl_q.ALUsrc;
  assign ex_ALUop     = ctrl_q.ALUop;
  assign ex_readData1 = rd1_q;
  assign ex_readData2 = rd2_q;
  assign ex_imm       = imm_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_dest      = dest_q;
  assign stall        = hz;
  assign pcWrite      = ~hz;
  assign ifidWrite    = ~hz;
  assign stallCount   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: hazard/bubble sequences,
// counter saturation, jump immunity and asynchronous reset.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 16;

  localparam logic [3:0] K_ADD  = 4'd0;
  localparam logic [3:0] K_SUB  = 4'd1;
  localparam logic [3:0] K_LW   = 4'd2;
  localparam logic [3:0] K_SW   = 4'd3;
  localparam logic [3:0] K_BEQ  = 4'd4;
  localparam logic [3:0] K_BNE  = 4'd5;
  localparam logic [3:0] K_ADDI = 4'd6;
  localparam logic [3:0] K_J    = 4'd7;

  typedef struct packed {
    logic rtype, lw, sw, beq, bne, j;
    logic regWrite, memToReg, memRead, memWrite, ALUsrc, regDest;
    logic [2:0]    op;
    logic [DW-1:0] d1, d2, imm;
    logic [RW-1:0] rs, rt, rd;
  } id_t;

  typedef struct packed {
    logic rw, m2r, mr, mw, as;
    logic [2:0]    op;
    logic [DW-1:0] d1, d2, imm;
    logic [RW-1:0] rs, rt, dest;
  } exo_t;

  typedef struct packed {
    logic          stall;
    exo_t          ex;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [3:0]    k;
    logic [RW-1:0] rs, rt, rd;
    logic          mr;
    logic [RW-1:0] mrd;
    logic          st;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rtype, lw, sw, beq, bne, j;
  logic regWrite, memToReg, memRead, memWrite, ALUsrc, regDest;
  logic [2:0]    ALUop;
  logic [DW-1:0] readData1, readData2, signExtImm;
  logic [RW-1:0] rs, rt, rd;
  logic          exmem_memRead;
  logic [RW-1:0] exmem_rd;
  logic ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_ALUsrc;
  logic [2:0]    ex_ALUop;
  logic [DW-1:0] ex_readData1, ex_readData2, ex_imm;
  logic [RW-1:0] ex_rs, ex_rt, ex_dest;
  logic          pcWrite, ifidWrite, stall;
  logic [CW-1:0] stallCount;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic [CW-1:0] m_cnt = '0;
  logic obs_stall, obs_pc, obs_if;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rtype(rtype), .lw(lw), .sw(sw), .beq(beq), .bne(bne), .j(j),
    .regWrite(regWrite), .memToReg(memToReg), .memRead(memRead),
    .memWrite(memWrite), .ALUsrc(ALUsrc), .regDest(regDest),
    .ALUop(ALUop),
    .readData1(readData1), .readData2(readData2),
    .signExtImm(signExtImm),
    .rs(rs), .rt(rt), .rd(rd),
    .exmem_memRead(exmem_memRead), .exmem_rd(exmem_rd),
    .ex_regWrite(ex_regWrite), .ex_memToReg(ex_memToReg),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_ALUsrc(ex_ALUsrc), .ex_ALUop(ex_ALUop),
    .ex_readData1(ex_readData1), .ex_readData2(ex_readData2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite),
    .stall(stall), .stallCount(stallCount)
  );

  function automatic id_t mk(input logic [3:0] k,
                             input logic [RW-1:0] s,
                             input logic [RW-1:0] t,
                             input logic [RW-1:0] d);
    id_t x;
    x = '0;
    x.d1 = $urandom;
    x.d2 = $urandom;
    x.imm = $urandom;
    x.rs = s;
    x.rt = t;
    x.rd = d;
    unique case (k)
      K_ADD: begin
        x.rtype = 1; x.regWrite = 1; x.regDest = 1; x.op = 3'b000;
      end
      K_SUB: begin
        x.rtype = 1; x.regWrite = 1; x.regDest = 1; x.op = 3'b001;
      end
      K_LW: begin
        x.lw = 1; x.regWrite = 1; x.memToReg = 1;
        x.memRead = 1; x.ALUsrc = 1; x.op = 3'b000;
      end
      K_SW: begin
        x.sw = 1; x.memWrite = 1; x.ALUsrc = 1; x.op = 3'b000;
      end
      K_BEQ:  begin x.beq = 1; x.op = 3'b001; end
      K_BNE:  begin x.bne = 1; x.op = 3'b001; end
      K_ADDI: begin
        x.regWrite = 1; x.ALUsrc = 1; x.op = 3'b000;
      end
      default: begin x.j = 1; x.op = 3'b111; end
    endcase
    return x;
  endfunction

  function automatic exo_t ex_obs();
    return '{rw: ex_regWrite, m2r: ex_memToReg, mr: ex_memRead,
             mw: ex_memWrite, as: ex_ALUsrc, op: ex_ALUop,
             d1: ex_readData1, d2: ex_readData2, imm: ex_imm,
             rs: ex_rs, rt: ex_rt, dest: ex_dest};
  endfunction

  task automatic apply(input id_t x);
    rtype = x.rtype; lw = x.lw; sw = x.sw;
    beq = x.beq; bne = x.bne; j = x.j;
    regWrite = x.regWrite; memToReg = x.memToReg;
    memRead = x.memRead; memWrite = x.memWrite;
    ALUsrc = x.ALUsrc; regDest = x.regDest; ALUop = x.op;
    readData1 = x.d1; readData2 = x.d2; signExtImm = x.imm;
    rs = x.rs; rt = x.rt; rd = x.rd;
  endtask

  // Drive one ID-stage cycle; the expected EX contents go on the scoreboard.
  task automatic issue(input id_t x, input logic mr,
                       input logic [RW-1:0] mrd, input logic st);
    exp_t e;
    apply(x);
    exmem_memRead = mr;
    exmem_rd = mrd;
    #1;
    obs_stall = stall;
    obs_pc = pcWrite;
    obs_if = ifidWrite;
    if (st && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    e.stall = st;
    e.cnt = m_cnt;
    if (st)
      e.ex = '{rw: 0, m2r: 0, mr: 0, mw: 0, as: 0, op: 3'b111,
               d1: x.d1, d2: x.d2, imm: x.imm,
               rs: x.rs, rt: x.rt, dest: '0};
    else
      e.ex = '{rw: x.regWrite, m2r: x.memToReg, mr: x.memRead,
               mw: x.memWrite, as: x.ALUsrc, op: x.op,
               d1: x.d1, d2: x.d2, imm: x.imm,
               rs: x.rs, rt: x.rt,
               dest: x.regDest ? x.rd : x.rt};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    apply('0);
    exmem_memRead = 0;
    exmem_rd = '0;
    @(posedge clk);
    #1;
    sb.push_back('{stall: 1'b0, cnt: '0,
                   ex: '{op: 3'b111, default: '0}});
    e = sb.pop_front();
    n_cmp++;
    if (ex_obs() !== e.ex || stallCount !== e.cnt) begin
      n_bad++;
      $display("FAIL reset_ex: got %h cnt %h, need %h cnt %h",
               ex_obs(), stallCount, e.ex, e.cnt);
    end
    n_cmp++;
    if (pcWrite !== 1'b1 || ifidWrite !== 1'b1 || stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_wr: pc=%b ifid=%b stall=%b, need 1 1 0",
               pcWrite, ifidWrite, stall);
    end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    step_t s[6];
    exp_t  e;
    s = '{'{K_LW,  5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0},
          '{K_ADD, 5'd2, 5'd4, 5'd3, 1'b0, 5'd0, 1'b1},
          '{K_ADD, 5'd2, 5'd4, 5'd3, 1'b0, 5'd0, 1'b0},
          '{K_LW,  5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0},
          '{K_SUB, 5'd4, 5'd2, 5'd5, 1'b0, 5'd0, 1'b1},
          '{K_SUB, 5'd4, 5'd2, 5'd5, 1'b0, 5'd0, 1'b0}};
    foreach (s[n]) begin
      issue(mk(s[n].k, s[n].rs, s[n].rt, s[n].rd),
            s[n].mr, s[n].mrd, s[n].st);
      e = sb.pop_front();
      n_cmp++;
      if (obs_stall !== e.stall || obs_pc !== !e.stall ||
          obs_if !== !e.stall) begin
        n_bad++;
        $display("FAIL load_use_stall[%0d]: stall=%b pc=%b ifid=%b, need stall=%b",
                 n, obs_stall, obs_pc, obs_if, e.stall);
      end
      n_cmp++;
      if (ex_obs() !== e.ex || stallCount !== e.cnt) begin
        n_bad++;
        $display("FAIL load_use_ex[%0d]: got %h cnt %h, need %h cnt %h",
                 n, ex_obs(), stallCount, e.ex, e.cnt);
      end
    end
  endtask

  task automatic test_load_branch();
    step_t s[4];
    exp_t  e;
    s = '{'{K_LW,  5'd1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0},
          '{K_BEQ, 5'd5, 5'd6, 5'd0, 1'b0, 5'd0, 1'b1},
          '{K_BEQ, 5'd5, 5'd6, 5'd0, 1'b1, 5'd5, 1'b1},
          '{K_BEQ, 5'd5, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0}};
    foreach (s[n]) begin
      issue(mk(s[n].k, s[n].rs, s[n].rt, s[n].rd),
            s[n].mr, s[n].mrd, s[n].st);
      e = sb.pop_front();
      n_cmp++;
      if (obs_stall !== e.stall || obs_pc !== !e.stall) begin
        n_bad++;
        $display("FAIL load_br_stall[%0d]: stall=%b pc=%b, need stall=%b",
                 n, obs_stall, obs_pc, e.stall);
      end
      n_cmp++;
      if (ex_obs() !== e.ex || stallCount !== e.cnt) begin
        n_bad++;
        $display("FAIL load_br_ex[%0d]: got %h cnt %h, need %h cnt %h",
                 n, ex_obs(), stallCount, e.ex, e.cnt);
      end
    end
  endtask

  task automatic test_alu_branch();
    step_t s[5];
    exp_t  e;
    s = '{'{K_ADD, 5'd1, 5'd2, 5'd7, 1'b0, 5'd0, 1'b0},
          '{K_BNE, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1},
          '{K_BNE, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0},
          '{K_ADD, 5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0},
          '{K_BNE, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0}};
    foreach (s[n]) begin
      issue(mk(s[n].k, s[n].rs, s[n].rt, s[n].rd),
            s[n].mr, s[n].mrd, s[n].st);
      e = sb.pop_front();
      n_cmp++;
      if (obs_stall !== e.stall || obs_if !== !e.stall) begin
        n_bad++;
        $display("FAIL alu_br_stall[%0d]: stall=%b ifid=%b, need stall=%b",
                 n, obs_stall, obs_if, e.stall);
      end
      n_cmp++;
      if (ex_obs() !== e.ex || stallCount !== e.cnt) begin
        n_bad++;
        $display("FAIL alu_br_ex[%0d]: got %h cnt %h, need %h cnt %h",
                 n, ex_obs(), stallCount, e.ex, e.cnt);
      end
    end
  endtask

  task automatic test_store_imm();
    step_t s[5];
    exp_t  e;
    s = '{'{K_LW,   5'd1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0},
          '{K_SW,   5'd8, 5'd9, 5'd0, 1'b0, 5'd0, 1'b1},
          '{K_SW,   5'd8, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0},
          '{K_LW,   5'd1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0},
          '{K_ADDI, 5'd1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0}};
    foreach (s[n]) begin
      issue(mk(s[n].k, s[n].rs, s[n].rt, s[n].rd),
            s[n].mr, s[n].mrd, s[n].st);
      e = sb.pop_front();
      n_cmp++;
      if (obs_stall !== e.stall) begin
        n_bad++;
        $display("FAIL store_imm_stall[%0d]: stall=%b, need %b",
                 n, obs_stall, e.stall);
      end
      n_cmp++;
      if (ex_obs() !== e.ex || stallCount !== e.cnt) begin
        n_bad++;
        $display("FAIL store_imm_ex[%0d]: got %h cnt %h, need %h cnt %h",
                 n, ex_obs(), stallCount, e.ex, e.cnt);
      end
    end
  endtask

  task automatic test_saturation();
    id_t  x;
    exp_t e;
    x = mk(K_BEQ, 5'd5, 5'd6, 5'd0);
    apply(x);
    exmem_memRead = 1'b1;
    exmem_rd = 5'd5;
    for (int c = 0; c < (1 << CW) + 2; c++) begin
      @(posedge clk);
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
    #1;
    issue(x, 1'b1, 5'd5, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if (obs_stall !== 1'b1 || ex_obs() !== e.ex) begin
      n_bad++;
      $display("FAIL sat_bubble: stall=%b ex %h, need 1 ex %h",
               obs_stall, ex_obs(), e.ex);
    end
    n_cmp++;
    if (stallCount !== {CW{1'b1}}) begin
      n_bad++;
      $display("FAIL sat_count: got %h, need %h",
               stallCount, {CW{1'b1}});
    end
  endtask

  task automatic test_jump();
    step_t s[2];
    exp_t  e;
    s = '{'{K_LW, 5'd1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0},
          '{K_J,  5'd5, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0}};
    foreach (s[n]) begin
      issue(mk(s[n].k, s[n].rs, s[n].rt, s[n].rd),
            s[n].mr, s[n].mrd, s[n].st);
      e = sb.pop_front();
      n_cmp++;
      if (obs_stall !== e.stall || ex_obs() !== e.ex ||
          stallCount !== e.cnt) begin
        n_bad++;
        $display("FAIL jump[%0d]: stall=%b ex %h cnt %h, need %b %h %h",
                 n, obs_stall, ex_obs(), stallCount,
                 e.stall, e.ex, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    issue(mk(K_LW, 5'd1, 5'd2, 5'd0), 1'b0, 5'd0, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (ex_obs() !== e.ex) begin
      n_bad++;
      $display("FAIL mid_lw: got %h, need %h", ex_obs(), e.ex);
    end
    apply(mk(K_ADD, 5'd2, 5'd4, 5'd3));
    #1;
    n_cmp++;
    if (stall !== 1'b1 || pcWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_pre: stall=%b pc=%b, need 1 0", stall, pcWrite);
    end
    #1 rst = 1'b1;
    #1;
    m_cnt = '0;
    sb.push_back('{stall: 1'b0, cnt: '0,
                   ex: '{op: 3'b111, default: '0}});
    e = sb.pop_front();
    n_cmp++;
    if (ex_obs() !== e.ex || stallCount !== e.cnt) begin
      n_bad++;
      $display("FAIL mid_reset_ex: got %h cnt %h, need %h cnt %h",
               ex_obs(), stallCount, e.ex, e.cnt);
    end
    n_cmp++;
    if (pcWrite !== 1'b1 || ifidWrite !== 1'b1 || stall !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_wr: pc=%b ifid=%b stall=%b, need 1 1 0",
               pcWrite, ifidWrite, stall);
    end
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    issue(mk(K_ADD, 5'd2, 5'd4, 5'd3), 1'b0, 5'd0, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (obs_stall !== 1'b0 || ex_obs() !== e.ex ||
        stallCount !== e.cnt) begin
      n_bad++;
      $display("FAIL mid_after: stall=%b ex %h cnt %h, need 0 %h %h",
               obs_stall, ex_obs(), stallCount, e.ex, e.cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_store_imm();
    test_saturation();
    test_jump();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
